display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Parametrised scan controller for the display adaptor. It generalises the two-buffer display state machine to NBUF frame buffers with configurable raster timing. It generates the pixel and line counters, sync, blanking and buffer read addressing, and uses a full/release handshake with the buffer writer. If the next buffer is not full at frame end, it repeats the current frame and flags an underflow instead of reading a partially written buffer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- NBUF, 2, number of frame buffers (must be >= 2)
- PX_W, 10, Pxout width (holds H_TOTAL-1)
- LN_W, 10, Lineout width (holds V_TOTAL-1)
- ADDR_W, 19, RdAddr width (holds H_ACTIVE*V_ACTIVE-1)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- CSDisplay  in  1  display enable
- BufFull  in  NBUF  writer marks buffer i full; held until BufRelease[i]
- BufRelease  out  NBUF  one-cycle pulse, buffer i consumed and returned to writer
- SelBuf  out  NBUF  one-hot, buffer currently scanned
- RE  out  1  read enable, high on active pixels
- RdAddr  out  ADDR_W  linear pixel address within SelBuf
- Pxout  out  PX_W  pixel counter
- Lineout  out  LN_W  line counter
- SelBlank  out  1  high outside the active area and when not scanning
- HSyncN  out  1  horizontal sync, active-low
- VSyncN  out  1  vertical sync, active-low
- FrameStart  out  1  pulse on the first cycle of each frame
- Underflow  out  1  pulse when a frame is repeated

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the same sum over the V parameters.
- States: IDLE, WAIT_BUF, SCAN.
  - IDLE → WAIT_BUF when CSDisplay = 1.
  - WAIT_BUF → SCAN when BufFull[current index] = 1.
- In IDLE and WAIT_BUF:
  - Pxout and Lineout are held at 0.
  - RE = 0, SelBlank = 1, HSyncN = 1, VSyncN = 1.
- In SCAN:
  - Pxout increments every cycle and wraps at H_TOTAL-1. Lineout increments on that wrap and itself wraps at V_TOTAL-1.
  - Active area: Pxout < H_ACTIVE and Lineout < V_ACTIVE. In the active area RE = 1 and SelBlank = 0. RdAddr increments after each active cycle.
  - HSyncN = 0 for H_ACTIVE+H_FP <= Pxout < H_ACTIVE+H_FP+H_SYNC.
  - VSyncN = 0 for V_ACTIVE+V_FP <= Lineout < V_ACTIVE+V_FP+V_SYNC, across whole lines.
- Frame-end decision, taken in the cycle where Pxout = H_TOTAL-1 and Lineout = V_TOTAL-1:
  - CSDisplay = 0: release the current buffer, advance the index, go to IDLE.
  - CSDisplay = 1 and BufFull[next] = 1: release the current buffer, advance the index modulo NBUF, continue in SCAN.
  - CSDisplay = 1 and BufFull[next] = 0: pulse Underflow, no release, keep the index, rescan the same buffer.
- CSDisplay deasserted mid-frame: the current frame completes normally; the stop is applied at frame end.
- Writer rule: BufFull[i] must fall within one cycle after BufRelease[i]. The controller does not sample BufFull[i] again until the index returns to i.
- Reset values:
  - State IDLE, index 0, SelBuf = 1 (bit 0).
  - Pxout, Lineout, RdAddr = 0.
  - RE, BufRelease, FrameStart, Underflow = 0.
  - SelBlank, HSyncN, VSyncN = 1.

## Timing
- All outputs are registered. RE, RdAddr, SelBlank and the syncs describe the same cycle as the Pxout/Lineout values presented alongside them.
- IDLE→WAIT_BUF and WAIT_BUF→SCAN each take one cycle after the input is sampled high.
- The first SCAN cycle shows Pxout = 0, Lineout = 0, RdAddr = 0, RE = 1, FrameStart = 1.
- The frame-end decision is sampled at the last frame cycle. BufRelease and Underflow pulse in the next cycle, which is either the new frame's FrameStart cycle or the first IDLE cycle.
- When the index advances, SelBuf changes in the FrameStart cycle. RdAddr returns to 0 in every FrameStart cycle.
- Asynchronous reset forces the reset values immediately, including mid-frame, and clears any pending release.
- Frame period in steady state is exactly H_TOTAL*V_TOTAL cycles, with no bubble at a swap or a repeat.

## Test plan
All scenarios use H = 4/1/2/1 (H_TOTAL 8), V = 3/1/1/1 (V_TOTAL 6) and NBUF = 3, giving a 48-cycle frame.
- Startup: reset, then CSDisplay = 1 and BufFull = 001 → SCAN after 2 cycles with FrameStart. RE is high at Pxout 0-3 on Lineout 0-2, and RdAddr runs 0..11. HSyncN is low at Pxout 5-6, VSyncN is low on Lineout 4, and SelBlank is the inverse of RE.
- Swap: BufFull = 011 before frame end → BufRelease = 001 for one cycle, coincident with FrameStart. SelBuf = 010 and RdAddr = 0 in that cycle.
- Underflow: BufFull[next] = 0 at frame end → Underflow pulses once, BufRelease stays 0, SelBuf unchanged, and RdAddr restarts at 0 for the repeated frame.
- Wrap: keep all buffers refilled after release → SelBuf sequence 001→010→100→001 over 4 frames, with a release pulse for each buffer.
- Stop: CSDisplay drops at Lineout 1 → the frame completes, BufRelease pulses for the current buffer, the controller enters IDLE with SelBlank = 1 and Pxout = Lineout = 0, and SelBuf is advanced.
- Reset mid-scan: reset asserted at Pxout 2, Lineout 1 → all outputs take their reset values without waiting for a clock edge, and no BufRelease is issued.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Raster scan controller for an NBUF-deep frame buffer ring.
// Generates timing, sync, blanking and read addressing; repeats a frame on underflow.
module display_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int NBUF     = 2,
  parameter int PX_W     = 10,
  parameter int LN_W     = 10,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CSDisplay,
  input  logic [NBUF-1:0]   BufFull,
  output logic [NBUF-1:0]   BufRelease,
  output logic [NBUF-1:0]   SelBuf,
  output logic              RE,
  output logic [ADDR_W-1:0] RdAddr,
  output logic [PX_W-1:0]   Pxout,
  output logic [LN_W-1:0]   Lineout,
  output logic              SelBlank,
  output logic              HSyncN,
  output logic              VSyncN,
  output logic              FrameStart,
  output logic              Underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(H_TOTAL - 1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SCAN
  } state_t;

  state_t r_state;

  logic            w_scan;
  logic            w_px_wrap;
  logic            w_ln_wrap;
  logic            w_last;
  logic            w_cur_full;
  logic            w_nxt_full;
  logic [NBUF-1:0] w_nsel;
  logic [PX_W-1:0] w_px_n;
  logic [LN_W-1:0] w_ln_n;
  logic            w_act_n;
  logic            w_hs_n;
  logic            w_vs_n;

  assign w_scan     = (r_state == S_SCAN);
  assign w_px_wrap  = (Pxout == PX_LAST);
  assign w_ln_wrap  = (Lineout == LN_LAST);
  assign w_last     = w_scan && w_px_wrap && w_ln_wrap;
  assign w_nsel     = {SelBuf[NBUF-2:0], SelBuf[NBUF-1]};
  assign w_cur_full = |(BufFull & SelBuf);
  assign w_nxt_full = |(BufFull & w_nsel);

  // Position of the cycle about to be presented; outside SCAN it is the origin.
  always_comb begin
    w_px_n = '0;
    w_ln_n = '0;
    if (w_scan) begin
      w_px_n = w_px_wrap ? '0 : Pxout + PX_W'(1);
      w_ln_n = Lineout;
      if (w_px_wrap) begin
        w_ln_n = w_ln_wrap ? '0 : Lineout + LN_W'(1);
      end
    end
  end

  assign w_act_n = (int'(w_px_n) < H_ACTIVE) &&
                   (int'(w_ln_n) < V_ACTIVE);
  assign w_hs_n  = (int'(w_px_n) >= HS_BEG) &&
                   (int'(w_px_n) < HS_END);
  assign w_vs_n  = (int'(w_ln_n) >= VS_BEG) &&
                   (int'(w_ln_n) < VS_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      SelBuf     <= NBUF'(1);
      BufRelease <= '0;
      RE         <= 1'b0;
      RdAddr     <= '0;
      Pxout      <= '0;
      Lineout    <= '0;
      SelBlank   <= 1'b1;
      HSyncN     <= 1'b1;
      VSyncN     <= 1'b1;
      FrameStart <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      BufRelease <= '0;
      FrameStart <= 1'b0;
      Underflow  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (CSDisplay) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_cur_full) begin
            r_state    <= S_SCAN;
            FrameStart <= 1'b1;
            RdAddr     <= '0;
            Pxout      <= w_px_n;
            Lineout    <= w_ln_n;
            RE         <= w_act_n;
            SelBlank   <= !w_act_n;
            HSyncN     <= !w_hs_n;
            VSyncN     <= !w_vs_n;
          end
        end
        S_SCAN: begin
          if (w_last && !CSDisplay) begin
            r_state    <= S_IDLE;
            BufRelease <= SelBuf;
            SelBuf     <= w_nsel;
            RdAddr     <= '0;
            Pxout      <= '0;
            Lineout    <= '0;
            RE         <= 1'b0;
            SelBlank   <= 1'b1;
            HSyncN     <= 1'b1;
            VSyncN     <= 1'b1;
          end else begin
            Pxout    <= w_px_n;
            Lineout  <= w_ln_n;
            RE       <= w_act_n;
            SelBlank <= !w_act_n;
            HSyncN   <= !w_hs_n;
            VSyncN   <= !w_vs_n;
            if (w_last) begin
              FrameStart <= 1'b1;
              RdAddr     <= '0;
              // Never read a partially written buffer: repeat instead.
              if (w_nxt_full) begin
                BufRelease <= SelBuf;
                SelBuf     <= w_nsel;
              end else begin
                Underflow <= 1'b1;
              end
            end else begin
              RdAddr <= RdAddr + ADDR_W'(RE);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl on an 8x6 raster with three buffers.
// Frame events go through a scoreboard queue; a monitor checks raster timing.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CSDisplay = 1'b0;
  logic [2:0] BufFull = 3'b000;
  logic [2:0] BufRelease;
  logic [2:0] SelBuf;
  logic       RE;
  logic [3:0] RdAddr;
  logic [2:0] Pxout;
  logic [2:0] Lineout;
  logic       SelBlank;
  logic       HSyncN;
  logic       VSyncN;
  logic       FrameStart;
  logic       Underflow;

  display_scan_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .NBUF(3), .PX_W(3), .LN_W(3), .ADDR_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .CSDisplay(CSDisplay),
    .BufFull(BufFull),
    .BufRelease(BufRelease),
    .SelBuf(SelBuf),
    .RE(RE),
    .RdAddr(RdAddr),
    .Pxout(Pxout),
    .Lineout(Lineout),
    .SelBlank(SelBlank),
    .HSyncN(HSyncN),
    .VSyncN(VSyncN),
    .FrameStart(FrameStart),
    .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fs;
    logic       ufl;
    logic       per;
    logic [2:0] sel;
    logic [2:0] rel;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endfunction

  function automatic ev_t ev(logic fs, logic ufl, logic per,
                             logic [2:0] sel, logic [2:0] rel);
    ev_t e;
    e.fs  = fs;
    e.ufl = ufl;
    e.per = per;
    e.sel = sel;
    e.rel = rel;
    return e;
  endfunction

  // Buffer writer: fills on request, drops a flag right after its release.
  logic [2:0] fill_mask = 3'b000;
  int         fill_seq  = 0;
  int         fill_seen = 0;

  always @(negedge clk) begin
    if (fill_seq != fill_seen) begin
      fill_seen = fill_seq;
      BufFull   = BufFull | fill_mask;
    end
    BufFull = BufFull & ~BufRelease;
  end

  task automatic fill(input logic [2:0] m);
    fill_mask = m;
    fill_seq++;
  endtask

  // Monitor: frame events against the queue, raster against a cycle counter.
  int   c = 48;
  int   m_px;
  int   m_ln;
  logic m_act;
  ev_t  e;

  always @(negedge clk) begin
    if (reset) begin
      c = 48;
    end else begin
      if (FrameStart || Underflow || (|BufRelease)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got fs=%0b ufl=%0b rel=%b sel=%b, required none",
                   FrameStart, Underflow, BufRelease, SelBuf);
        end else begin
          e = exp_q.pop_front();
          chk("ev_framestart", FrameStart, e.fs);
          chk("ev_underflow", Underflow, e.ufl);
          chk("ev_release", BufRelease, e.rel);
          chk("ev_selbuf", SelBuf, e.sel);
          if (e.fs) chk("ev_rdaddr", RdAddr, 0);
          if (e.per) chk("frame_period", c + 1, 48);
        end
      end
      if (FrameStart) c = 0;
      else if (c < 1000) c++;
      if (c < 48) begin
        m_px  = c % 8;
        m_ln  = c / 8;
        m_act = (m_px < 4) && (m_ln < 3);
        chk("pxout", Pxout, m_px);
        chk("lineout", Lineout, m_ln);
        chk("re", RE, m_act);
        chk("selblank", SelBlank, !m_act);
        chk("hsyncn", HSyncN, !(m_px == 5 || m_px == 6));
        chk("vsyncn", VSyncN, m_ln != 4);
        if (m_act) chk("rdaddr", RdAddr, m_ln * 4 + m_px);
      end
    end
  end

  task automatic chk_reset(string t);
    chk({t, "_selbuf"}, SelBuf, 1);
    chk({t, "_pxout"}, Pxout, 0);
    chk({t, "_lineout"}, Lineout, 0);
    chk({t, "_rdaddr"}, RdAddr, 0);
    chk({t, "_re"}, RE, 0);
    chk({t, "_release"}, BufRelease, 0);
    chk({t, "_framestart"}, FrameStart, 0);
    chk({t, "_underflow"}, Underflow, 0);
    chk({t, "_selblank"}, SelBlank, 1);
    chk({t, "_hsyncn"}, HSyncN, 1);
    chk({t, "_vsyncn"}, VSyncN, 1);
  endtask

  task automatic wait_fs(string nm);
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = FrameStart;
    end
    chk(nm, seen, 1);
  endtask

  task automatic wait_rel(string nm);
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = |BufRelease;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset("rst0");
    @(negedge clk) reset = 1'b0;

    // Startup: two cycles to reach SCAN
    exp_q.push_back(ev(1, 0, 0, 3'b001, 3'b000));
    @(posedge clk);
    #1 CSDisplay = 1'b1;
    fill(3'b001);
    @(posedge clk);
    #1 chk("start_wait_fs", FrameStart, 0);
    chk("start_wait_blank", SelBlank, 1);
    @(posedge clk);
    #1 chk("start_fs", FrameStart, 1);
    chk("start_re", RE, 1);

    // Swap to buffer 1
    exp_q.push_back(ev(1, 0, 1, 3'b010, 3'b001));
    repeat (20) @(posedge clk);
    #1 fill(3'b011);
    wait_fs("swap_fs");

    // Buffer 2 empty at frame end: repeat buffer 1
    exp_q.push_back(ev(1, 1, 1, 3'b010, 3'b000));
    wait_fs("ufl_fs");

    // Keep everything full: 010 -> 100 -> 001 -> 010
    exp_q.push_back(ev(1, 0, 1, 3'b100, 3'b010));
    repeat (20) @(posedge clk);
    #1 fill(3'b111);
    wait_fs("wrap_fs1");
    exp_q.push_back(ev(1, 0, 1, 3'b001, 3'b100));
    repeat (20) @(posedge clk);
    #1 fill(3'b111);
    wait_fs("wrap_fs2");
    exp_q.push_back(ev(1, 0, 1, 3'b010, 3'b001));
    repeat (20) @(posedge clk);
    #1 fill(3'b111);
    wait_fs("wrap_fs3");

    // Stop requested at Lineout 1; frame completes first
    exp_q.push_back(ev(0, 0, 0, 3'b100, 3'b010));
    repeat (8) @(posedge clk);
    #1 CSDisplay = 1'b0;
    fill(3'b111);
    wait_rel("stop_rel");
    chk("stop_selblank", SelBlank, 1);
    chk("stop_pxout", Pxout, 0);
    chk("stop_lineout", Lineout, 0);
    chk("stop_re", RE, 0);
    chk("stop_framestart", FrameStart, 0);
    repeat (3) @(posedge clk);
    #1 chk("idle_pxout", Pxout, 0);
    chk("idle_selblank", SelBlank, 1);
    chk("idle_selbuf", SelBuf, 3'b100);

    // Restart on buffer 2, then reset mid-frame
    exp_q.push_back(ev(1, 0, 0, 3'b100, 3'b000));
    CSDisplay = 1'b1;
    wait_fs("restart_fs");
    repeat (10) @(posedge clk);
    #2 chk("mid_pxout", Pxout, 2);
    chk("mid_lineout", Lineout, 1);
    reset = 1'b1;
    #1 chk_reset("rst_mid");
    repeat (3) @(posedge clk);
    #1 chk_reset("rst_hold");
    CSDisplay = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("post_selblank", SelBlank, 1);
    chk("post_selbuf", SelBuf, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
